// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 4-digit scan controller with a shadow/display buffer that swaps only at frame boundaries.
// Optional feature macro SEG_LEADING_ZERO_BLANK_EN: when defined, leading zero digits 3..1 are kept dark.
module seg_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  nib_out,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);
  localparam int MX = DIV > BLANK_CYC ? DIV : BLANK_CYC;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  idx_q, nxt_idx;
  logic [3:0]  an_q, nib_q, sdp_q, ddp_q, sdp_d, ddp_d;
  logic        dp_q, fd_q, pend_q, pend_d, xfer, blk;
  logic [15:0] shd_q, dsp_q, shd_d, dsp_d;
  assign nib_out    = nib_q;
  assign an_n       = an_q;
  assign dp_n       = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;
  // A load coinciding with a transfer passes straight through because shd_d already holds it.
  always_comb begin
    shd_d   = load ? value : shd_q;
    sdp_d   = load ? dp_in : sdp_q;
    xfer    = state_q == IDLE || fd_q;
    dsp_d   = xfer ? shd_d : dsp_q;
    ddp_d   = xfer ? sdp_d : ddp_q;
    pend_d  = !xfer && (pend_q || load);
    nxt_idx = idx_q + 2'd1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blk     = idx_q != 2'd0 && (dsp_d >> {idx_q, 2'b00}) == 16'd0;
`else
    blk     = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'hF;
      dp_q    <= 1'b1;
      nib_q   <= 4'd0;
      fd_q    <= 1'b0;
      shd_q   <= 16'd0;
      dsp_q   <= 16'd0;
      sdp_q   <= 4'd0;
      ddp_q   <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      dsp_q  <= dsp_d;
      sdp_q  <= sdp_d;
      ddp_q  <= ddp_d;
      pend_q <= pend_d;
      fd_q   <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= 2'd0;
        an_q    <= 4'hF;
        dp_q    <= 1'b1;
        nib_q   <= dsp_d[3:0];
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
            nib_q   <= dsp_d[3:0];
          end
          GUARD: begin
            nib_q <= dsp_d[{idx_q, 2'b00} +: 4];
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
              state_q <= ON;
              cnt_q   <= '0;
              an_q    <= blk ? 4'hF : ~(4'b0001 << idx_q);
              dp_q    <= blk | ~ddp_d[idx_q];
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            if (cnt_q == CW'(DIV - 1)) begin
              state_q <= GUARD;
              cnt_q   <= '0;
              idx_q   <= nxt_idx;
              an_q    <= 4'hF;
              dp_q    <= 1'b1;
              nib_q   <= dsp_d[{nxt_idx, 2'b00} +: 4];
            end else begin
              cnt_q <= cnt_q + 1'b1;
              fd_q  <= idx_q == 2'd3 && cnt_q == CW'(DIV - 2);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenario bench for seg_scan_ctrl with DIV=4, BLANK_CYC=2 (frame = 24 cycles).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [3:0]  nib_out, an_n;
  logic        dp_n, frame_done;
  logic [1:0]  digit_idx;
  int checks = 0, errors = 0;

  seg_scan_ctrl #(.DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .nib_out(nib_out), .an_n(an_n), .dp_n(dp_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    tick(); tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp f", an_n); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp_n); end
    checks++; if (nib_out !== 4'd0) begin errors++; $display("FAIL reset_nib got %h exp 0", nib_out); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
  endtask

  task automatic test_scan();
    logic [3:0] ea, en;
    logic ed;
    rst = 1'b0; enable = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'b0101;
    tick();
    load = 1'b0;
    for (int k = 0; k < 24; k++) begin
      int d;
      bit g;
      if (k > 0) tick();
      d = k / 6; g = (k % 6) < 2;
      ea = g ? 4'hF : ~(4'b0001 << d);
      en = 4'(4 - d);
      ed = g ? 1'b1 : ~dp_in[d];
      checks++; if (an_n !== ea) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an_n, ea); end
      checks++; if (nib_out !== en) begin errors++; $display("FAIL scan_nib k=%0d got %h exp %h", k, nib_out, en); end
      checks++; if (dp_n !== ed) begin errors++; $display("FAIL scan_dp k=%0d got %b exp %b", k, dp_n, ed); end
      checks++; if (digit_idx !== 2'(d)) begin errors++; $display("FAIL scan_idx k=%0d got %0d exp %0d", k, digit_idx, d); end
      checks++; if (frame_done !== (k == 23)) begin errors++; $display("FAIL scan_fd k=%0d got %b exp %b", k, frame_done, k == 23); end
    end
  endtask

  task automatic test_mid_load();
    logic [3:0] ea;
    for (int k = 0; k < 24; k++) begin
      int d;
      tick();
      d = k / 6;
      ea = (k % 6) < 2 ? 4'hF : ~(4'b0001 << d);
      checks++; if (nib_out !== 4'(4 - d)) begin errors++; $display("FAIL midload_nib k=%0d got %h exp %h", k, nib_out, 4'(4 - d)); end
      checks++; if (an_n !== ea) begin errors++; $display("FAIL midload_an k=%0d got %b exp %b", k, an_n, ea); end
      if (k == 12) begin checks++; if (dut.pend_q !== 1'b1) begin errors++; $display("FAIL midload_pend got %b exp 1", dut.pend_q); end end
      if (k == 8) begin load = 1'b1; value = 16'hABCD; end
      if (k == 9) load = 1'b0;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL midload_fd got %b exp 1", frame_done); end
    tick();
    checks++; if (nib_out !== 4'hD) begin errors++; $display("FAIL midload_newnib got %h exp d", nib_out); end
    checks++; if (dut.pend_q !== 1'b0) begin errors++; $display("FAIL midload_pendclr got %b exp 0", dut.pend_q); end
    tick(); tick();
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL midload_on_an got %b exp 1110", an_n); end
    checks++; if (nib_out !== 4'hD) begin errors++; $display("FAIL midload_on_nib got %h exp d", nib_out); end
  endtask

  task automatic test_frame_load();
    repeat (21) tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fload_fd got %b exp 1", frame_done); end
    load = 1'b1; value = 16'h5555; dp_in = 4'b0000;
    tick();
    load = 1'b0;
    checks++; if (nib_out !== 4'h5) begin errors++; $display("FAIL fload_nib got %h exp 5", nib_out); end
    checks++; if (dut.pend_q !== 1'b0) begin errors++; $display("FAIL fload_pend got %b exp 0", dut.pend_q); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fload_fdlow got %b exp 0", frame_done); end
    tick(); tick();
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL fload_an got %b exp 1110", an_n); end
    checks++; if (nib_out !== 4'h5) begin errors++; $display("FAIL fload_on_nib got %h exp 5", nib_out); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL fload_dp got %b exp 1", dp_n); end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    repeat (12) tick();
    checks++; if (an_n !== 4'b1011) begin errors++; $display("FAIL endrop_pre_an got %b exp 1011", an_n); end
    enable = 1'b0;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL endrop_an got %b exp 1111", an_n); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL endrop_idx got %0d exp 0", digit_idx); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL endrop_dp got %b exp 1", dp_n); end
    tick();
    enable = 1'b1;
    while (n < 20) begin
      tick(); n++;
      if (an_n !== 4'hF) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL enrise_latency got %0d exp 3", n); end
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL enrise_an got %b exp 1110", an_n); end
  endtask

  task automatic test_reset_mid();
    repeat (6) tick();
    checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL rstmid_pre_an got %b exp 1101", an_n); end
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL rstmid_an got %b exp 1111", an_n); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL rstmid_dp got %b exp 1", dp_n); end
    checks++; if (nib_out !== 4'd0) begin errors++; $display("FAIL rstmid_nib got %h exp 0", nib_out); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL rstmid_idx got %0d exp 0", digit_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd got %b exp 0", frame_done); end
    checks++; if (dut.dsp_q !== 16'd0) begin errors++; $display("FAIL rstmid_disp got %h exp 0", dut.dsp_q); end
    rst = 1'b0; load = 1'b0;
    tick();
    checks++; if (nib_out !== 4'd0) begin errors++; $display("FAIL rstmid_loaddrop got %h exp 0", nib_out); end
    checks++; if (dut.pend_q !== 1'b0) begin errors++; $display("FAIL rstmid_pend got %b exp 0", dut.pend_q); end
  endtask

  task automatic test_blank();
    logic [3:0] ea;
    logic ed;
    enable = 1'b0;
    tick();
    load = 1'b1; value = 16'h0070; dp_in = 4'hF; enable = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 24; k++) begin
      int d;
      bit off, bl;
      if (k > 0) tick();
      d = k / 6;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      bl = d >= 2;
`else
      bl = 1'b0;
`endif
      off = (k % 6) < 2 || bl;
      ea = off ? 4'hF : ~(4'b0001 << d);
      ed = off;
      checks++; if (an_n !== ea) begin errors++; $display("FAIL blank_an k=%0d got %b exp %b", k, an_n, ea); end
      checks++; if (dp_n !== ed) begin errors++; $display("FAIL blank_dp k=%0d got %b exp %b", k, dp_n, ed); end
      checks++; if (nib_out !== (d == 1 ? 4'h7 : 4'h0)) begin errors++; $display("FAIL blank_nib k=%0d got %h", k, nib_out); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_load();
    test_frame_load();
    test_enable_drop();
    test_reset_mid();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
